// File: rtl/uart_mem_loader.sv
// UART boot loader: receives a little-endian word count, then that many
// little-endian words over 8N1 serial, and writes them to memory.
module uart_mem_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_on,
  input  logic        rx,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rstate_t;

  typedef enum logic [1:0] {
    L_HDR, L_DATA, L_DONE, L_ERR
  } lstate_t;

  rstate_t rstate;
  lstate_t lstate;

  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          start_ok;
  logic          stop_err;

  logic [1:0]    bcnt;
  logic [23:0]   word_lo;
  logic [31:0]   asm_word;
  logic [31:0]   nwords;
  logic [31:0]   widx;
  logic          live;

  assign asm_word = {rx_byte, word_lo};
  assign live     = (lstate == L_HDR) || (lstate == L_DATA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstate     <= R_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      start_ok   <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      start_ok   <= 1'b0;
      stop_err   <= 1'b0;
      if (!uart_on) begin
        rstate <= R_IDLE;
        cnt    <= '0;
        idx    <= '0;
      end else begin
        unique case (rstate)
          R_IDLE: begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s && !done && !frame_err)
              rstate <= R_START;
          end
          R_START: begin
            if (cnt == HALF) begin
              cnt <= '0;
              if (!rx_s) begin
                rstate   <= R_DATA;
                start_ok <= 1'b1;
              end else begin
                rstate <= R_IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          R_DATA: begin
            if (cnt == LAST) begin
              cnt        <= '0;
              shreg[idx] <= rx_s;
              idx        <= idx + 1'b1;
              if (idx == 3'd7)
                rstate <= R_STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          R_STOP: begin
            if (cnt == LAST) begin
              cnt    <= '0;
              rstate <= R_IDLE;
              if (rx_s) begin
                byte_valid <= 1'b1;
                rx_byte    <= shreg;
              end else begin
                stop_err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: rstate <= R_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lstate    <= L_HDR;
      bcnt      <= '0;
      word_lo   <= '0;
      nwords    <= '0;
      widx      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok && live)
        busy <= 1'b1;
      if (!uart_on) begin
        // Abort drops partial progress but keeps sticky status.
        if (live) begin
          lstate <= L_HDR;
          bcnt   <= '0;
          widx   <= '0;
          busy   <= 1'b0;
        end
      end else if (stop_err && live) begin
        lstate    <= L_ERR;
        frame_err <= 1'b1;
        busy      <= 1'b0;
      end else if (byte_valid && live) begin
        word_lo <= asm_word[31:8];
        bcnt    <= bcnt + 1'b1;
        if (bcnt == 2'd3) begin
          unique case (lstate)
            L_HDR: begin
              if (asm_word == 32'd0) begin
                lstate <= L_DONE;
                done   <= 1'b1;
                busy   <= 1'b0;
              end else if (asm_word > 32'(MAX_WORDS)) begin
                lstate    <= L_ERR;
                frame_err <= 1'b1;
                busy      <= 1'b0;
              end else begin
                lstate <= L_DATA;
                nwords <= asm_word;
                widx   <= '0;
              end
            end
            L_DATA: begin
              mem_we    <= 1'b1;
              mem_addr  <= BASE_ADDR + (widx << 2);
              mem_wdata <= asm_word;
              widx      <= widx + 1'b1;
              if (widx == nwords - 1'b1) begin
                lstate <= L_DONE;
                done   <= 1'b1;
                busy   <= 1'b0;
              end
            end
            L_DONE: ;
            L_ERR: ;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/uart_mem_loader.md
UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868 (100 MHz / 115200 baud), clock cycles per UART bit; legal range 4 and up.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written.
REQ-003 Parameter MAX_WORDS, default 256, largest accepted word count.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 uart_on  input  1  load enable; when 0 the block ignores rx and holds idle outputs.
REQ-007 rx  input  1  UART serial line, idle high, 8N1, LSB first, asynchronous to clk.
REQ-008 mem_we  output  1  one-cycle write strobe to instr/data memory.
REQ-009 mem_addr  output  32  byte address of the write, word aligned.
REQ-010 mem_wdata  output  32  write data.
REQ-011 busy  output  1  high from the first accepted start bit until done or error.
REQ-012 done  output  1  sticky high once all words are written.
REQ-013 frame_err  output  1  sticky high on stop-bit error or count > MAX_WORDS.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer (preset to 1) before use; latency of 2 cycles is acceptable.
REQ-015 Receiver FSM SHALL have states R_IDLE, R_START, R_DATA, R_STOP with one bit-period counter and a 3-bit bit index.
REQ-016 R_IDLE -> R_START on synchronized rx = 0 while uart_on = 1, done = 0 and frame_err = 0.
REQ-017 R_START: at CLKS_PER_BIT/2 cycles, rx = 0 -> R_DATA with counter cleared; rx = 1 (glitch) -> R_IDLE with no byte and no error.
REQ-018 R_DATA: sample rx every CLKS_PER_BIT cycles into bit [index], LSB first; after bit 7 -> R_STOP.
REQ-019 R_STOP: sample after CLKS_PER_BIT cycles; rx = 1 -> emit one-cycle byte_valid, then R_IDLE; rx = 0 -> set frame_err, R_IDLE.
REQ-020 Loader FSM SHALL have states L_HDR, L_DATA, L_DONE, L_ERR.
REQ-021 Bytes SHALL be assembled little-endian, so the first byte goes to bits [7:0] and the fourth byte to bits [31:24].
REQ-022 L_HDR: the 4th byte completes word count N.
REQ-023 In L_HDR, N = 0 -> L_DONE.
REQ-024 In L_HDR, N > MAX_WORDS -> L_ERR with frame_err set.
REQ-025 In L_HDR, any other N -> L_DATA with word index i = 0.
REQ-026 L_DATA: on the 4th byte of each word, assert mem_we for exactly one cycle, the cycle after byte_valid, with mem_addr = BASE_ADDR + 4*i and mem_wdata = the assembled word; then i <= i+1.
REQ-027 After the write of word i = N-1 -> L_DONE; done rises in the same cycle as that final mem_we.
REQ-028 L_DONE and L_ERR are terminal and are left only by reset; further rx traffic SHALL produce no mem_we.
REQ-029 uart_on falling mid-frame SHALL abort: both FSMs return to R_IDLE/L_HDR, the byte and word counters clear, busy drops, and no mem_we is issued; done and frame_err are unaffected.
REQ-030 mem_addr SHALL wrap modulo 2^32 and carries no overflow flag.
REQ-031 mem_addr and mem_wdata SHALL hold their last values when mem_we = 0.

Reset
REQ-032 reset = 0 SHALL force, asynchronously: R_IDLE, L_HDR, all counters 0, synchronizer flops 1, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, busy 0, done 0, frame_err 0.
REQ-033 reset asserted mid-byte or mid-word SHALL discard partial data; after release the block accepts a fresh header.

Verification
REQ-034 CLKS_PER_BIT = 16, send header 02 00 00 00 then 78 56 34 12 EF BE AD DE -> exactly two mem_we pulses: (0x0, 0x12345678) and (0x4, 0xDEADBEEF); done = 1 with the second pulse; busy = 0 afterwards.
REQ-035 A 3-cycle low glitch on rx while idle -> no byte received, frame_err = 0; a valid frame sent afterwards is received correctly.
REQ-036 A byte sent with stop bit = 0 -> frame_err = 1, no mem_we, later frames ignored.
REQ-037 Header with N = 257 and MAX_WORDS = 256 -> frame_err = 1, zero writes.
REQ-038 Header with N = 0 -> done = 1 after the 4th header byte, zero writes.
REQ-039 Bring reset low during the 2nd data byte of word 0, release it, then resend the full stream from REQ-034 -> outputs equal those of REQ-034, with no write from the aborted stream.
